program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
- Parametrised successor to the free-running program counter: produces the instruction-memory address each cycle.
- Adds jumps, conditional branch and skip, subroutine call/return through an internal return-address stack, halt, and enable gating.
- Sits between the instruction decoder (which drives OP/COND/TARGET) and the combinational instruction memory (which consumes ADDR).

Parameters:
- ADDR_WIDTH, 4, width of the instruction address; address space is 2^ADDR_WIDTH words.
- STACK_DEPTH, 4, number of return-address entries; must be >= 1.
- RESET_VECTOR, 0, value loaded into ADDR on reset.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- EN  input  1  advance enable; 0 freezes all state.
- OP  input  3  sequencing operation for this cycle.
- COND  input  1  condition flag for BRANCH and SKIP.
- TARGET  input  ADDR_WIDTH  destination address for JUMP, BRANCH and CALL.
- ADDR  output  ADDR_WIDTH  current instruction address (registered).
- SP  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
- HALTED  output  1  sticky; set by HALT.
- STK_OVF  output  1  sticky; CALL attempted with the stack full.
- STK_UNF  output  1  sticky; RET attempted with the stack empty.

Behaviour:
- Reset (RST=0, asynchronous, no clock needed): ADDR=RESET_VECTOR, SP=0, HALTED=0, STK_OVF=0, STK_UNF=0. Stack contents are don't-care.
- Release is sampled synchronously; the first update is on the first rising edge with RST=1.
- All outputs are registered. OP, COND and TARGET are sampled on the edge, and their effect appears on ADDR one cycle later.
- Memory data for ADDR is therefore valid in the same cycle as ADDR.
- No update occurs when EN=0 or HALTED=1: every register holds and OP is ignored.
- OP encoding (EN=1, HALTED=0); all address arithmetic is modulo 2^ADDR_WIDTH, so all-ones + 1 wraps to 0:
  - 000 NEXT: ADDR <= ADDR+1.
  - 001 JUMP: ADDR <= TARGET.
  - 010 BRANCH: ADDR <= COND ? TARGET : ADDR+1.
  - 011 CALL:
    - If SP < STACK_DEPTH: push ADDR+1, SP <= SP+1, ADDR <= TARGET.
    - Else: STK_OVF <= 1, no push, ADDR <= ADDR+1.
  - 100 RET:
    - If SP > 0: ADDR <= top entry, SP <= SP-1.
    - Else: STK_UNF <= 1, ADDR <= ADDR+1.
  - 101 HALT: HALTED <= 1, ADDR holds. Only reset clears HALTED.
  - 110 SKIP: ADDR <= COND ? ADDR+2 : ADDR+1.
  - 111 HOLD: ADDR holds; the cycle is consumed.
- Stack is LIFO.
  - A push writes entry[SP]; a pop reads entry[SP-1].
  - No simultaneous push and pop is possible, since there is one OP per cycle.
- Pushed return value wraps: CALL at address all-ones pushes 0.
- Error flags are sticky until reset. Once set, they do not block later legal CALL or RET operations.
- Reset asserted mid-operation overrides any OP in flight. SP returns to 0 and the stack is considered empty.
- No combinational path exists from any input to ADDR.

Decomposition:
- Shared package holds:
  - OP_NEXT..OP_HOLD 3-bit localparams/defines.
  - A clog2 helper function.
- The decoder includes the same package.
- One natural sub-module, return_stack: a parametrised LIFO with CLK/RST, PUSH, POP, DIN, DOUT, FULL, EMPTY and COUNT.
  - return_stack instantiates the storage array.
  - program_sequencer keeps the ADDR register, the next-address mux, and the sticky flags.

Test Plan (ADDR_WIDTH=4, STACK_DEPTH=2, RESET_VECTOR=0):
- Hold RST=0 for 20 ns, then release with OP=NEXT, EN=1:
  - ADDR is 0 during reset.
  - ADDR then counts 1,2,…,15,0, wrapping after the 16th edge.
- At ADDR=3:
  - JUMP TARGET=9 -> ADDR=9.
  - BRANCH COND=0 TARGET=2 -> 10.
  - BRANCH COND=1 TARGET=2 -> 2.
  - SKIP COND=1 -> 4.
  - EN=0 for 3 cycles -> ADDR stays 4.
- At ADDR=5:
  - CALL TARGET=12 -> ADDR=12, SP=1.
  - CALL TARGET=14 -> ADDR=14, SP=2.
  - RET -> 13, SP=1.
  - RET -> 6, SP=0.
  - STK_OVF=0 and STK_UNF=0 throughout.
- Overflow and underflow:
  - With SP=2 at ADDR=7, CALL TARGET=1 -> ADDR=8, SP=2, STK_OVF=1.
  - Drain with two RETs; a third RET -> ADDR=+1, STK_UNF=1. Both flags stay 1.
- At ADDR=15:
  - CALL TARGET=4 pushes 0.
  - A subsequent RET -> ADDR=0.
- HALT at ADDR=6:
  - ADDR stays 6 and HALTED=1 for 10 cycles of random OP.
  - Assert RST mid-cycle (not on an edge): ADDR=0, HALTED=0 and SP=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg: shared op encodings, sequencer state type and clog2 helper
package program_sequencer_pkg;
  localparam logic [2:0] OP_NEXT   = 3'b000;
  localparam logic [2:0] OP_JUMP   = 3'b001;
  localparam logic [2:0] OP_BRANCH = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;
  localparam logic [2:0] OP_HALT   = 3'b101;
  localparam logic [2:0] OP_SKIP   = 3'b110;
  localparam logic [2:0] OP_HOLD   = 3'b111;
  typedef enum logic {ST_RUN, ST_HALT} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/program_sequencer_if.sv
// program_sequencer_if: decoder-to-sequencer control and address/status bundle
interface program_sequencer_if
  import program_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int STACK_DEPTH = 4
);
  logic                                 en;
  logic [2:0]                           op;
  logic                                 cond;
  logic [ADDR_WIDTH-1:0]                target;
  logic [ADDR_WIDTH-1:0]                addr;
  logic [clog2(STACK_DEPTH+1)-1:0]      sp;
  logic                                 halted;
  logic                                 stk_ovf;
  logic                                 stk_unf;
  modport master (output en, op, cond, target, input addr, sp, halted, stk_ovf, stk_unf);
  modport slave  (input en, op, cond, target, output addr, sp, halted, stk_ovf, stk_unf);
endinterface

// File: rtl/program_sequencer_return_stack.sv
// return_stack: parametrised LIFO of return addresses; push writes entry[count], pop reads entry[count-1]
module return_stack
  import program_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int CW = clog2(DEPTH + 1),
  localparam int IW = DEPTH > 1 ? clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic wr, rd;
  always_comb begin
    full  = count == CW'(DEPTH);
    empty = count == '0;
    wr    = push && !full;
    rd    = pop && !empty;
    dout  = mem[IW'(count - CW'(1))];
  end
  always_ff @(posedge clk)
    if (wr) mem[IW'(count)] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (wr) count <= count + CW'(1);
    else if (rd) count <= count - CW'(1);
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: registered instruction address with jump/branch/skip, call/return stack, halt and enable gating
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    STACK_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic                clk,
  input logic                rst_n,
  program_sequencer_if.slave bus
);
  localparam int SW = clog2(STACK_DEPTH + 1);
  state_t state, state_n;
  logic act, push, pop, full, empty, ovf, unf;
  logic [ADDR_WIDTH-1:0] addr, addr_n, inc, top;
  logic [SW-1:0] sp;
  return_stack #(.WIDTH(ADDR_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
    .clk, .rst_n, .push, .pop, .din(inc), .dout(top), .full, .empty, .count(sp)
  );
  always_comb begin
    act     = bus.en && state == ST_RUN;
    inc     = addr + ADDR_WIDTH'(1);
    push    = act && bus.op == OP_CALL && !full;
    pop     = act && bus.op == OP_RET && !empty;
    state_n = act && bus.op == OP_HALT ? ST_HALT : state;
    addr_n  = !act                                   ? addr :
              bus.op == OP_JUMP                      ? bus.target :
              bus.op == OP_BRANCH                    ? (bus.cond ? bus.target : inc) :
              bus.op == OP_CALL                      ? (full ? inc : bus.target) :
              bus.op == OP_RET                       ? (empty ? inc : top) :
              bus.op == OP_SKIP                      ? (bus.cond ? addr + ADDR_WIDTH'(2) : inc) :
              bus.op == OP_HALT || bus.op == OP_HOLD ? addr : inc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_RUN;
      addr  <= RESET_VECTOR;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      ovf   <= ovf | (act && bus.op == OP_CALL && full);
      unf   <= unf | (act && bus.op == OP_RET && empty);
    end
  assign bus.addr    = addr;
  assign bus.sp      = sp;
  assign bus.halted  = state == ST_HALT;
  assign bus.stk_ovf = ovf;
  assign bus.stk_unf = unf;
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed scoreboard bench for program_sequencer (ADDR_WIDTH=4, STACK_DEPTH=2)
module tb_program_sequencer;
  import program_sequencer_pkg::*;
  typedef struct packed {
    logic [3:0] addr;
    logic [1:0] sp;
    logic       h;
    logic       o;
    logic       u;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  exp_t q[$];
  program_sequencer_if #(.ADDR_WIDTH(4), .STACK_DEPTH(2)) bus ();
  program_sequencer #(.ADDR_WIDTH(4), .STACK_DEPTH(2), .RESET_VECTOR(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic expect_state(input logic [3:0] a, input logic [1:0] s, input logic h, input logic o, input logic u);
    q.push_back('{addr: a, sp: s, h: h, o: o, u: u});
  endtask
  task automatic check(input string tag);
    exp_t x, g;
    x = q.pop_front();
    g = '{addr: bus.addr, sp: bus.sp, h: bus.halted, o: bus.stk_ovf, u: bus.stk_unf};
    compared++;
    assert (g === x) else begin
      mismatched++;
      $error("FAIL %s: observed addr=%0d sp=%0d halted=%b ovf=%b unf=%b expected addr=%0d sp=%0d halted=%b ovf=%b unf=%b",
             tag, g.addr, g.sp, g.h, g.o, g.u, x.addr, x.sp, x.h, x.o, x.u);
    end
  endtask
  task automatic step(input logic [2:0] op, input logic c, input logic [3:0] t, input logic e,
                      input logic [3:0] a, input logic [1:0] s, input logic h, input logic o, input logic u,
                      input string tag);
    bus.op = op;
    bus.cond = c;
    bus.target = t;
    bus.en = e;
    expect_state(a, s, h, o, u);
    @(posedge clk);
    #1;
    check(tag);
  endtask
  initial begin
    bus.en = 1'b1;
    bus.op = OP_NEXT;
    bus.cond = 1'b0;
    bus.target = 4'd0;
    #12;
    expect_state(4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("reset");
    #8 rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) step(OP_NEXT, 0, 0, 1, 4'(i), 0, 0, 0, 0, "count_wrap");
    for (int i = 1; i <= 3; i++) step(OP_NEXT, 0, 0, 1, 4'(i), 0, 0, 0, 0, "count");
    step(OP_JUMP,   0, 9, 1, 9,  0, 0, 0, 0, "jump");
    step(OP_BRANCH, 0, 2, 1, 10, 0, 0, 0, 0, "branch_not_taken");
    step(OP_BRANCH, 1, 2, 1, 2,  0, 0, 0, 0, "branch_taken");
    step(OP_SKIP,   1, 0, 1, 4,  0, 0, 0, 0, "skip_taken");
    for (int i = 0; i < 3; i++) step(OP_JUMP, 1, 11, 0, 4, 0, 0, 0, 0, "enable_low");
    step(OP_NEXT,   0, 0,  1, 5,  0, 0, 0, 0, "next_after_en");
    step(OP_CALL,   0, 12, 1, 12, 1, 0, 0, 0, "call1");
    step(OP_CALL,   0, 14, 1, 14, 2, 0, 0, 0, "call2");
    step(OP_RET,    0, 0,  1, 13, 1, 0, 0, 0, "ret1");
    step(OP_RET,    0, 0,  1, 6,  0, 0, 0, 0, "ret2");
    step(OP_SKIP,   0, 0,  1, 7,  0, 0, 0, 0, "skip_not_taken");
    step(OP_HOLD,   0, 0,  1, 7,  0, 0, 0, 0, "hold");
    step(OP_JUMP,   0, 6,  1, 6,  0, 0, 0, 0, "jump6");
    step(OP_CALL,   0, 5,  1, 5,  1, 0, 0, 0, "fill1");
    step(OP_CALL,   0, 7,  1, 7,  2, 0, 0, 0, "fill2");
    step(OP_CALL,   0, 1,  1, 8,  2, 0, 1, 0, "overflow");
    step(OP_RET,    0, 0,  1, 6,  1, 0, 1, 0, "drain1");
    step(OP_RET,    0, 0,  1, 7,  0, 0, 1, 0, "drain2");
    step(OP_RET,    0, 0,  1, 8,  0, 0, 1, 1, "underflow");
    step(OP_JUMP,   0, 15, 1, 15, 0, 0, 1, 1, "jump15");
    step(OP_CALL,   0, 4,  1, 4,  1, 0, 1, 1, "call_wrap");
    step(OP_RET,    0, 0,  1, 0,  0, 0, 1, 1, "ret_wrap");
    step(OP_CALL,   0, 6,  1, 6,  1, 0, 1, 1, "call_to_6");
    step(OP_HALT,   0, 0,  1, 6,  1, 1, 1, 1, "halt");
    for (int i = 0; i < 10; i++)
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
           6, 1, 1, 1, 1, "halted_hold");
    #3 rst_n = 1'b0;
    bus.en = 1'b1;
    bus.op = OP_NEXT;
    #1;
    expect_state(4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("async_reset");
    @(posedge clk);
    #1;
    expect_state(4'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("reset_held");
    rst_n = 1'b1;
    step(OP_NEXT, 0, 0, 1, 1, 0, 0, 0, 0, "resume");
    step(OP_RET,  0, 0, 1, 2, 0, 0, 0, 1, "stack_empty_after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
